// File: rtl/wb4_arbiter.sv
// wb4_arbiter: round-robin, cycle-locked arbiter that lets MCNT Wishbone B4
// pipelined masters share one pipelined slave port. The owner keeps the bus
// for as long as its cyc stays high. A pending-request counter caps the
// number of outstanding strobes, and a watchdog synthesises an ack if the
// slave stops answering.
module wb4_arbiter #(
    parameter int ARCHBITSZ = 16,
    parameter int MCNT      = 2,
    parameter int PENDMAX   = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                        rst_i,
    input  logic                        clk_i,
    input  logic [MCNT-1:0]             m_cyc_i,
    input  logic [MCNT-1:0]             m_stb_i,
    input  logic [MCNT-1:0]             m_we_i,
    input  logic [MCNT*ARCHBITSZ-1:0]   m_addr_i,
    input  logic [MCNT*ARCHBITSZ-1:0]   m_data_i,
    input  logic [MCNT*ARCHBITSZ/8-1:0] m_sel_i,
    output logic [MCNT-1:0]             m_stall_o,
    output logic [MCNT-1:0]             m_ack_o,
    output logic [ARCHBITSZ-1:0]        m_data_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    output logic                        s_we_o,
    output logic [ARCHBITSZ-1:0]        s_addr_o,
    output logic [ARCHBITSZ-1:0]        s_data_o,
    output logic [ARCHBITSZ/8-1:0]      s_sel_o,
    input  logic                        s_stall_i,
    input  logic                        s_ack_i,
    input  logic [ARCHBITSZ-1:0]        s_data_i,
    output logic [MCNT-1:0]             gnt_o,
    output logic                        tmo_o
);

    localparam int SELW = ARCHBITSZ / 8;
    localparam int OW   = (MCNT > 1) ? $clog2(MCNT) : 1;
    localparam int PW   = $clog2(PENDMAX + 1);
    localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    logic [0:0]    state_reg, state_next;
    logic [OW-1:0] owner_reg, owner_next;
    logic [OW-1:0] rr_reg,    rr_next;
    logic [PW-1:0] pend_reg,  pend_next;
    logic [TW-1:0] wdog_reg,  wdog_next;

    logic                 win_found;
    logic [OW-1:0]        win_idx;
    logic                 own_cyc, own_stb, own_we;
    logic [ARCHBITSZ-1:0] own_addr, own_data;
    logic [SELW-1:0]      own_sel;
    logic                 owned, pend_full, pend_nz;
    logic                 real_ack, wd_ack, route_ack, accept;

    // Round-robin search starting just after the last owner, so the
    // previous owner ranks lowest.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= MCNT; k++) begin
            idx = (int'(rr_reg) + k) % MCNT;
            if (!win_found && m_cyc_i[idx]) begin
                win_found = 1'b1;
                win_idx   = OW'(idx);
            end
        end
    end

    // Select the current owner's request signals.
    always_comb begin
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        own_we   = 1'b0;
        own_addr = '0;
        own_data = '0;
        own_sel  = '0;
        for (int i = 0; i < MCNT; i++) begin
            if (owner_reg == OW'(i)) begin
                own_cyc  = m_cyc_i[i];
                own_stb  = m_stb_i[i];
                own_we   = m_we_i[i];
                own_addr = m_addr_i[i*ARCHBITSZ +: ARCHBITSZ];
                own_data = m_data_i[i*ARCHBITSZ +: ARCHBITSZ];
                own_sel  = m_sel_i[i*SELW +: SELW];
            end
        end
    end

    assign owned     = (state_reg == ST_OWNED);
    assign pend_full = (pend_reg == PW'(PENDMAX));
    assign pend_nz   = (pend_reg != '0);

    // Slave side is quiet unless a master owns the bus; all of it is derived
    // from asynchronously reset state, so reset silences it immediately.
    assign s_cyc_o  = owned && own_cyc;
    assign s_stb_o  = owned && own_stb && !pend_full;
    assign s_we_o   = owned && own_we;
    assign s_addr_o = owned ? own_addr : '0;
    assign s_data_o = owned ? own_data : '0;
    assign s_sel_o  = owned ? own_sel  : '0;

    // Acks with nothing outstanding are stray and never reach a master.
    // A real ack in the same cycle as watchdog expiry wins.
    assign real_ack  = owned && s_ack_i && pend_nz;
    assign wd_ack    = owned && (TIMEOUT > 0) && pend_nz && !s_ack_i &&
                       (wdog_reg == TW'(TIMEOUT));
    assign route_ack = real_ack || wd_ack;
    assign accept    = s_stb_o && !s_stall_i;
    assign m_data_o  = real_ack ? s_data_i : '0;
    assign tmo_o     = wd_ack;

    // Per-master grant, stall and ack fan-out.
    generate
        for (genvar gi = 0; gi < MCNT; gi++) begin : g_master
            assign gnt_o[gi]     = owned && (owner_reg == OW'(gi));
            assign m_stall_o[gi] = gnt_o[gi] ? (s_stall_i || pend_full) : 1'b1;
            assign m_ack_o[gi]   = gnt_o[gi] && route_ack;
        end
    endgenerate

    // Next-state: grant, release, pending count and watchdog.
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        rr_next    = rr_reg;
        pend_next  = pend_reg;
        wdog_next  = wdog_reg;
        if (state_reg == ST_IDLE) begin
            pend_next = '0;
            wdog_next = '0;
            if (win_found) begin
                state_next = ST_OWNED;
                owner_next = win_idx;
                rr_next    = win_idx;
            end
        end else if (!own_cyc) begin
            state_next = ST_IDLE;
            pend_next  = '0;
            wdog_next  = '0;
        end else begin
            if (accept && !route_ack) begin
                pend_next = pend_reg + PW'(1);
            end else if (!accept && route_ack) begin
                pend_next = pend_reg - PW'(1);
            end
            if ((TIMEOUT == 0) || !pend_nz || s_ack_i || wd_ack) begin
                wdog_next = '0;
            end else begin
                wdog_next = wdog_reg + TW'(1);
            end
        end
    end

    // State registers; rr starts at the last master so master 0 wins first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            owner_reg <= '0;
            rr_reg    <= OW'(MCNT - 1);
            pend_reg  <= '0;
            wdog_reg  <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            rr_reg    <= rr_next;
            pend_reg  <= pend_next;
            wdog_reg  <= wdog_next;
        end
    end

endmodule

// File: tb/tb_wb4_arbiter.sv
// Directed testbench for wb4_arbiter (2 masters, 16-bit, PENDMAX=4, TIMEOUT=8).
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_wb4_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  m_cyc = '0, m_stb = '0, m_we = '0;
    logic [31:0] m_addr = '0, m_data = '0;
    logic [3:0]  m_sel = '0;
    logic [1:0]  m_stall, m_ack, gnt;
    logic [15:0] m_rdata, s_addr, s_wdata, s_rdata = '0;
    logic        s_cyc, s_stb, s_we, s_stall = 1'b0, s_ack = 1'b0, tmo;
    logic [1:0]  s_sel;

    int n_checks = 0;
    int n_fail   = 0;
    int acks, strobes;

    wb4_arbiter #(.ARCHBITSZ(16), .MCNT(2), .PENDMAX(4), .TIMEOUT(8)) dut (
        .rst_i(rst), .clk_i(clk),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_addr_i(m_addr), .m_data_i(m_data), .m_sel_i(m_sel),
        .m_stall_o(m_stall), .m_ack_o(m_ack), .m_data_o(m_rdata),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
        .s_addr_o(s_addr), .s_data_o(s_wdata), .s_sel_o(s_sel),
        .s_stall_i(s_stall), .s_ack_i(s_ack), .s_data_i(s_rdata),
        .gnt_o(gnt), .tmo_o(tmo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_all();
        tick(); m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0; s_stall = 1'b0;
        tick();
    endtask

    initial begin
        // ---------------- reset state
        tick(); settle();
        check_eq("rst_gnt", gnt, 2'b00);
        check_eq("rst_stall", m_stall, 2'b11);
        check_eq("rst_ack", m_ack, 2'b00);
        check_eq("rst_scyc", s_cyc, 1'b0);
        check_eq("rst_tmo", tmo, 1'b0);
        tick(); rst = 1'b0;

        // ---------------- single master 0 read of 0x0010
        tick(); m_cyc = 2'b01; m_stb = 2'b01; m_addr[15:0] = 16'h0010; m_sel = 4'b0011; settle();
        check_eq("t1_idle_gnt", gnt, 2'b00);
        tick(); settle();
        check_eq("t1_gnt", gnt, 2'b01);
        check_eq("t1_sstb", s_stb, 1'b1);
        check_eq("t1_saddr", s_addr, 16'h0010);
        check_eq("t1_ssel", s_sel, 2'b11);
        check_eq("t1_stall", m_stall, 2'b10);
        tick(); m_stb = 2'b00; settle();
        check_eq("t1_wait_ack", m_ack, 2'b00);
        tick(); s_ack = 1'b1; s_rdata = 16'hBEEF; settle();
        check_eq("t1_ack", m_ack, 2'b01);
        check_eq("t1_data", m_rdata, 16'hBEEF);
        tick(); settle();
        check_eq("t1_stray_dropped", m_ack, 2'b00);
        tick(); s_ack = 1'b0; m_cyc = 2'b00; settle();
        check_eq("t1_release_scyc", s_cyc, 1'b0);
        tick(); settle();
        check_eq("t1_idle_after", gnt, 2'b00);

        // ---------------- contention, fresh from reset (rr=1)
        rst = 1'b1; tick(); rst = 1'b0;
        tick(); m_cyc = 2'b11; settle();
        check_eq("t2_arb", gnt, 2'b00);
        tick(); settle();
        check_eq("t2_first", gnt, 2'b01);
        check_eq("t2_stall", m_stall, 2'b10);
        tick(); m_cyc = 2'b10; settle();
        check_eq("t2_m1_noack", m_ack[1], 1'b0);
        tick(); settle();
        check_eq("t2_gap1", gnt, 2'b00);
        tick(); settle();
        check_eq("t2_second", gnt, 2'b10);
        tick(); m_cyc = 2'b01; settle();
        tick(); settle();
        check_eq("t2_gap2", gnt, 2'b00);
        tick(); m_cyc = 2'b11; settle();
        check_eq("t2_third", gnt, 2'b01);
        tick(); m_cyc = 2'b10; settle();
        tick(); settle();
        check_eq("t2_gap3", gnt, 2'b00);
        tick(); settle();
        check_eq("t2_fourth", gnt, 2'b10);
        idle_all();

        // ---------------- locked read-modify-write by master 0 (rr=1)
        tick(); m_cyc = 2'b11; m_stb = 2'b01; m_addr[15:0] = 16'h0020; settle();
        tick(); settle();
        check_eq("t3_gnt", gnt, 2'b01);
        check_eq("t3_rd_stb", {s_stb, s_we}, 2'b10);
        tick(); m_stb = 2'b00; s_ack = 1'b1; s_rdata = 16'h1234; settle();
        check_eq("t3_rd_ack", m_ack, 2'b01);
        check_eq("t3_rd_data", m_rdata, 16'h1234);
        tick(); s_ack = 1'b0; m_stb = 2'b01; m_we = 2'b01; m_data[15:0] = 16'h1235; settle();
        check_eq("t3_wr_stb", {s_cyc, s_stb, s_we}, 3'b111);
        check_eq("t3_wr_data", s_wdata, 16'h1235);
        check_eq("t3_m1_stalled", m_stall[1], 1'b1);
        tick(); m_stb = 2'b00; s_ack = 1'b1; settle();
        check_eq("t3_wr_ack", m_ack, 2'b01);
        check_eq("t3_scyc_held", s_cyc, 1'b1);
        tick(); s_ack = 1'b0; m_we = 2'b00; m_cyc = 2'b10; settle();
        check_eq("t3_m1_still_stalled", m_stall, 2'b10);
        tick(); settle();
        check_eq("t3_gap", gnt, 2'b00);
        tick(); settle();
        check_eq("t3_m1_gnt", gnt, 2'b10);
        check_eq("t3_m1_stall", m_stall, 2'b01);
        idle_all();

        // ---------------- PENDMAX limit, master 0 (rr=1)
        acks = 0; strobes = 0;
        tick(); m_cyc = 2'b01; m_stb = 2'b01; m_addr[15:0] = 16'h0030;
        for (int i = 0; i < 4; i++) begin
            tick(); settle();
            if (s_stb && !s_stall) strobes++;
        end
        check_eq("t4_four_accepted", strobes, 4);
        tick(); settle();
        check_eq("t4_fifth_blocked", {s_stb, m_stall[0]}, 2'b01);
        tick(); s_ack = 1'b1; s_rdata = 16'h00A1; settle();
        if (m_ack[0]) acks++;
        check_eq("t4_still_blocked", s_stb, 1'b0);
        tick(); s_ack = 1'b0; settle();
        check_eq("t4_fifth_go", {s_stb, m_stall[0]}, 2'b10);
        if (s_stb && !s_stall) strobes++;
        tick(); m_stb = 2'b00;
        for (int i = 0; i < 4; i++) begin
            s_ack = 1'b1; settle();
            if (m_ack[0]) acks++;
            tick();
        end
        settle();
        check_eq("t4_extra_stray", m_ack, 2'b00);
        check_eq("t4_strobes", strobes, 5);
        check_eq("t4_acks", acks, 5);
        idle_all();

        // ---------------- watchdog, master 1 (rr=0)
        tick(); m_cyc = 2'b10; m_stb = 2'b10; m_addr[31:16] = 16'h0040; s_rdata = 16'hFFFF;
        tick(); settle();
        check_eq("t5_gnt", gnt, 2'b10);
        check_eq("t5_stb", s_stb, 1'b1);
        acks = 0;
        tick(); m_stb = 2'b00;
        for (int i = 0; i < 8; i++) begin
            settle();
            if (m_ack != 2'b00 || tmo) acks++;
            tick();
        end
        settle();
        check_eq("t5_no_early_ack", acks, 0);
        check_eq("t5_tmo_ack", {m_ack, tmo}, 3'b101);
        check_eq("t5_tmo_data", m_rdata, 16'h0000);
        tick(); s_ack = 1'b1; settle();
        check_eq("t5_late_dropped", {m_ack, tmo}, 3'b000);
        idle_all();

        // ---------------- asynchronous reset with pending=3 (rr=1)
        tick(); m_cyc = 2'b01; m_stb = 2'b01; m_addr[15:0] = 16'h0050;
        tick(); tick(); tick();
        tick(); m_stb = 2'b00; s_ack = 1'b1; settle();
        check_eq("t6_busy", {s_cyc, m_ack[0]}, 2'b11);
        #1 rst = 1'b1; m_cyc = 2'b11; #1;
        check_eq("t6_rst_scyc", s_cyc, 1'b0);
        check_eq("t6_rst_gnt", gnt, 2'b00);
        check_eq("t6_rst_ack", m_ack, 2'b00);
        check_eq("t6_rst_stall", m_stall, 2'b11);
        check_eq("t6_rst_saddr", s_addr, 16'h0000);
        tick(); rst = 1'b0; s_ack = 1'b0;
        tick(); settle();
        check_eq("t6_first_after_rst", gnt, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/wb4_arbiter.md
Name: wb4_arbiter

Overview:
- Shares one Wishbone B4 pipelined slave bus among MCNT Wishbone B4 masters, e.g. several pi1-to-wb4 bridges feeding one memory or peripheral port.
- Arbitration is round-robin and locked for a whole cycle: the owner keeps the bus while its cyc_i stays high, so read-modify-write sequences stay atomic.
- A per-owner pending-request counter and a watchdog stop a non-responding slave from hanging the bus.

Parameters:
- ARCHBITSZ, 16: data/address width; legal values 16, 32, 64, 128, 256; sel width is ARCHBITSZ/8.
- MCNT, 2: number of masters; legal range 2..8.
- PENDMAX, 4: maximum accepted-but-unacked requests per owner; the pending counter is clog2(PENDMAX+1) bits.
- TIMEOUT, 255: idle-ack watchdog limit in cycles; 0 disables the watchdog.

Ports:
- rst_i  in  1  asynchronous, active-high reset
- clk_i  in  1  clock
- m_cyc_i  in  MCNT  per-master cyc
- m_stb_i  in  MCNT  per-master stb
- m_we_i  in  MCNT  per-master we
- m_addr_i  in  MCNT*ARCHBITSZ  packed addresses; master i at [i*ARCHBITSZ +: ARCHBITSZ]
- m_data_i  in  MCNT*ARCHBITSZ  packed write data, same packing as m_addr_i
- m_sel_i  in  MCNT*ARCHBITSZ/8  packed byte selects
- m_stall_o  out  MCNT  per-master stall
- m_ack_o  out  MCNT  per-master ack
- m_data_o  out  ARCHBITSZ  read data, broadcast to all masters
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side controls
- s_addr_o  out  ARCHBITSZ  slave address
- s_data_o  out  ARCHBITSZ  slave write data
- s_sel_o  out  ARCHBITSZ/8  slave byte selects
- s_stall_i  in  1  slave stall
- s_ack_i  in  1  slave ack
- s_data_i  in  ARCHBITSZ  slave read data
- gnt_o  out  MCNT  one-hot current owner; 0 when idle
- tmo_o  out  1  one-cycle pulse on each watchdog-synthesised ack

Behaviour:
- Registers: state (IDLE/OWNED), owner index, last-owner pointer rr, pending counter, watchdog counter.
- Asynchronous reset:
  - state=IDLE, gnt_o=0, rr=MCNT-1 so master 0 wins first, pending=0, watchdog=0, tmo_o=0.
  - All slave-side outputs read 0; m_ack_o=0; m_stall_o all 1.
  - Reset mid-transfer aborts it: s_cyc_o drops asynchronously and late s_ack_i is ignored.
- IDLE:
  - Winner = first i with m_cyc_i[i]=1, searching from rr+1 modulo MCNT.
  - Winner is registered and becomes owner next edge (1 cycle arbitration latency); rr<=winner.
  - During IDLE all m_stall_o=1, m_ack_o=0, s_cyc_o=0, s_stb_o=0.
- OWNED:
  - s_cyc_o=m_cyc_i[owner] combinationally; s_we_o/s_addr_o/s_data_o/s_sel_o come from owner.
  - s_stb_o=m_stb_i[owner] && pending<PENDMAX.
  - m_stall_o[owner]=s_stall_i || pending==PENDMAX; every other master has stall=1, ack=0.
  - m_ack_o[owner]=(s_ack_i && pending!=0) || watchdog ack.
  - m_data_o=s_data_i on a real ack, 0 otherwise.
- Pending counter:
  - +1 when s_stb_o && !s_stall_i; -1 on a routed ack; both in the same cycle leaves it unchanged.
  - s_ack_i while pending==0 is a stray ack: dropped, never routed.
- Release:
  - When m_cyc_i[owner]=0: state<=IDLE, pending<=0, watchdog<=0.
  - Re-arbitration takes one further cycle, so there are no back-to-back grants without an IDLE cycle.
  - The released owner ranks lowest next round.
- Watchdog (TIMEOUT>0):
  - Counts while pending!=0 && !s_ack_i; cleared on any ack or when pending==0.
  - At count==TIMEOUT: synthesise one ack to the owner with m_data_o=0, pending-1, tmo_o=1 for one cycle, counter to 0.
  - A slave ack that arrives later for that request is a stray ack and is dropped.
- Masters raising cyc while another owns the bus see stall=1 until granted. A master dropping cyc while not owner has no effect.

Test Plan:
- Single master 0: cyc/stb read of addr 0x0010 with slave ack after 2 cycles -> gnt_o=01 one cycle after cyc; one m_ack_o[0] pulse with m_data_o=s_data_i=0xBEEF; pending returns to 0.
- Masters 0 and 1 raise cyc on the same edge (out of reset, rr=1):
  - Grant order is 0 then 1, with one IDLE cycle between owners.
  - Master 1 sees stall=1 and no ack throughout master 0's ownership.
  - Repeated contention alternates 0,1,0,1.
- Locked RMW: master 0 issues read then write without dropping cyc while master 1 requests -> master 1 stays stalled until master 0 drops cyc; slave sees both strobes with s_cyc_o continuously high.
- PENDMAX=4: slave never stalls and acks late -> the 5th stb is stalled (s_stb_o=0) until the first ack; ack counts equal strobe counts.
- TIMEOUT=8: slave never acks one read -> 8 cycles after acceptance m_ack_o[owner]=1 with data 0 and tmo_o pulses once; a later slave ack is dropped.
- Assert rst_i mid-burst with pending=3 -> all outputs reach reset values without waiting for a clock edge; after release, master 0 is granted first.
